frame_buffer_mc: RTL

- Parametrised multi-channel frame buffer; next generation of the two-writer 640x480x8 pixel store.
- NUM_CH writers share one RAM write port through a round-robin ready/valid arbiter; one pipelined read port serves the VGA scan-out.
- Adds bounds checking, a hardware clear-screen sweep, write-drop reporting and read-valid signalling.
- Sits between the drawing engines and the VGA controller, all on one clock.

---
 rtl/fb_pkg.sv | 28 ++
 rtl/frame_buffer_mc_rr_arbiter.sv | 42 ++++
 rtl/frame_buffer_mc.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the multi-channel frame buffer: default geometry,
// memory sizing helpers, controller states and coordinate-to-address mapping.
package fb_pkg;

    localparam int H_RES_DEF   = 640;
    localparam int V_RES_DEF   = 480;
    localparam int COLOR_W_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

    function automatic int fb_depth(input int h_res, input int v_res);
        return h_res * v_res;
    endfunction

    function automatic int fb_addr_w(input int h_res, input int v_res);
        return (h_res * v_res > 1) ? $clog2(h_res * v_res) : 1;
    endfunction

    function automatic int unsigned xy_to_addr(input int unsigned x,
                                               input int unsigned y,
                                               input int unsigned h_res);
        return y * h_res + x;
    endfunction

endpackage

// File: rtl/frame_buffer_mc_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module rr_arbiter #(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] grant
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic [PTR_W-1:0] idx;

    // Scan from the farthest candidate back to the pointer so the nearest wins.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        idx     = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_CH);
            if (en && req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                ptr_nxt    = (int'(idx) == NUM_CH - 1) ? '0 : PTR_W'(int'(idx) + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/frame_buffer_mc.sv
// Multi-channel pixel store: arbitrated write port, two-stage read port for
// scan-out, and a hardware clear sweep that owns the write port while busy.
//
//   state | meaning
//   IDLE  | writers arbitrated, clear_start accepted
//   CLEAR | one pixel per cycle filled with the latched color, writers stalled
module frame_buffer_mc
    import fb_pkg::*;
#(
    parameter int                 H_RES    = H_RES_DEF,
    parameter int                 V_RES    = V_RES_DEF,
    parameter int                 COLOR_W  = COLOR_W_DEF,
    parameter int                 NUM_CH   = 2,
    parameter int                 X_W      = 10,
    parameter int                 Y_W      = 10,
    parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         wr_valid,
    input  logic [NUM_CH*X_W-1:0]     wr_x,
    input  logic [NUM_CH*Y_W-1:0]     wr_y,
    input  logic [NUM_CH*COLOR_W-1:0] wr_data,
    output logic [NUM_CH-1:0]         wr_ready,
    output logic                      wr_drop,
    input  logic                      rd_en,
    input  logic [X_W-1:0]            rd_x,
    input  logic [Y_W-1:0]            rd_y,
    output logic [COLOR_W-1:0]        rd_data,
    output logic                      rd_valid,
    input  logic                      clear_start,
    input  logic [COLOR_W-1:0]        clear_color,
    output logic                      busy,
    output logic                      clear_done
);

    localparam int DEPTH  = fb_depth(H_RES, V_RES);
    localparam int ADDR_W = fb_addr_w(H_RES, V_RES);

    fb_state_t          state, state_nxt;
    logic [ADDR_W-1:0]  clr_cnt, clr_cnt_nxt;
    logic [COLOR_W-1:0] clr_color, clr_color_nxt;
    logic               clear_done_nxt;

    logic [NUM_CH-1:0]  grant;
    logic [X_W-1:0]     gnt_x;
    logic [Y_W-1:0]     gnt_y;
    logic [COLOR_W-1:0] gnt_data;
    logic               wr_fire;
    logic               wr_in_range;
    logic [ADDR_W-1:0]  wr_addr;

    logic               ram_we;
    logic [ADDR_W-1:0]  ram_waddr;
    logic [COLOR_W-1:0] ram_wdata;
    logic [COLOR_W-1:0] mem [DEPTH];

    logic               rd_in_range;
    logic [ADDR_W-1:0]  rd_addr;
    logic [COLOR_W-1:0] rd_word;
    logic               rd_pend;
    logic               rd_in_range_q;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == IDLE),
        .req   (wr_valid),
        .grant (grant)
    );

    assign wr_ready = grant;
    assign wr_fire  = |grant;
    assign busy     = (state == CLEAR);

    always_comb begin
        gnt_x    = '0;
        gnt_y    = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                gnt_x    = wr_x[i*X_W +: X_W];
                gnt_y    = wr_y[i*Y_W +: Y_W];
                gnt_data = wr_data[i*COLOR_W +: COLOR_W];
            end
        end
    end

    assign wr_in_range = (32'(gnt_x) < 32'(H_RES)) && (32'(gnt_y) < 32'(V_RES));
    assign wr_addr     = ADDR_W'(xy_to_addr(32'(gnt_x), 32'(gnt_y), H_RES));
    assign rd_in_range = (32'(rd_x) < 32'(H_RES)) && (32'(rd_y) < 32'(V_RES));
    assign rd_addr     = ADDR_W'(xy_to_addr(32'(rd_x), 32'(rd_y), H_RES));

    always_comb begin
        state_nxt      = state;
        clr_cnt_nxt    = clr_cnt;
        clr_color_nxt  = clr_color;
        clear_done_nxt = 1'b0;
        ram_we         = 1'b0;
        ram_waddr      = wr_addr;
        ram_wdata      = gnt_data;
        case (state)
            IDLE: begin
                ram_we = wr_fire && wr_in_range;
                if (clear_start) begin
                    state_nxt     = CLEAR;
                    clr_cnt_nxt   = '0;
                    clr_color_nxt = clear_color;
                end
            end
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt;
                ram_wdata = clr_color;
                if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    state_nxt      = IDLE;
                    clear_done_nxt = 1'b1;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            clr_color  <= '0;
            clear_done <= 1'b0;
            wr_drop    <= 1'b0;
        end else begin
            state      <= state_nxt;
            clr_cnt    <= clr_cnt_nxt;
            clr_color  <= clr_color_nxt;
            clear_done <= clear_done_nxt;
            wr_drop    <= wr_fire && !wr_in_range;
        end
    end

    // The word is captured at the request edge, so a same-cycle write is not seen.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (rd_en) begin
            rd_word <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend       <= 1'b0;
            rd_in_range_q <= 1'b0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
        end else begin
            rd_pend  <= rd_en;
            rd_valid <= rd_pend;
            if (rd_en) begin
                rd_in_range_q <= rd_in_range;
            end
            if (rd_pend) begin
                rd_data <= rd_in_range_q ? rd_word : BG_COLOR;
            end
        end
    end

endmodule
